// File: rtl/ransac_pkg.sv
// ---------------------------------------------------------------------------
// ransac_pkg
// Shared definitions for the RANSAC iteration scheduler:
//   - ransac_state_e : sequencing states of ransac_iter_ctrl
//   - LFSR_DEFAULT   : reset value and replacement for an all-zero seed
//   - LFSR_TAPS      : feedback mask for the right-shifting Fibonacci LFSR
//                      (polynomial taps 16,14,13,11 -> state bits 0,2,3,5)
//   - lfsr16_next    : one LFSR step
// ---------------------------------------------------------------------------
package ransac_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PICK_A,
    PICK_B,
    REQ,
    WAIT_FIT,
    SCAN,
    DRAIN,
    UPDATE,
    NEXT,
    FINISH
  } ransac_state_e;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;

  // Shift right; the new MSB is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/ransac_lfsr16.sv
// ---------------------------------------------------------------------------
// ransac_lfsr16
// 16-bit Fibonacci LFSR used to draw sample indices.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (state -> LFSR_DEFAULT)
//   en_i    : advance one step this cycle
//   load_i  : load seed_i (zero seed replaced by LFSR_DEFAULT); wins over en_i
//   seed_i  : seed value
//   state_o : low OUT_W bits of the current state
// ---------------------------------------------------------------------------
module ransac_lfsr16
  import ransac_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [15:0]      seed_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      // An all-zero state would lock the register up.
      lfsr_d = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
    end else if (en_i) begin
      lfsr_d = lfsr16_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_DEFAULT;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/ransac_iter_ctrl.sv
// ---------------------------------------------------------------------------
// ransac_iter_ctrl
// Iteration scheduler for the RANSAC line-fit datapath. Per iteration it draws
// two distinct random point indices, hands them to the model-fit unit, streams
// every point index to the inlier scorer, counts inliers and keeps the best
// model. Sequencing only; no coordinate arithmetic.
//
// Optional feature macro: RANSAC_EARLY_EXIT_EN
//   adds input early_thr (latched at start) and output early_exit; a run stops
//   as soon as the best inlier count reaches a non-zero early_thr.
//
// Ports:
//   CLOCK_50, KEY          : clock, asynchronous active-low reset
//   start                  : one-cycle run request (ignored while busy)
//   num_points/num_iters/seed : run parameters, latched at start
//   busy, done             : run in progress / one-cycle end pulse
//   fit_req/fit_ack        : fit request handshake, fit_idx_a/b sample indices
//   fit_done/fit_ok        : fit result pulse, fit_ok=0 marks degenerate model
//   pt_valid/pt_idx        : point index stream to the scorer
//   inl_valid/inl_hit      : scorer results
//   best_valid/cnt/iter/a/b: best model so far (held until next start)
// ---------------------------------------------------------------------------
module ransac_iter_ctrl
  import ransac_pkg::*;
#(
  parameter int N_MAX  = 64,
  parameter int IDX_W  = 6,
  parameter int ITER_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_points,
  input  logic [ITER_W-1:0] num_iters,
  input  logic [15:0]       seed,
`ifdef RANSAC_EARLY_EXIT_EN
  input  logic [CNT_W-1:0]  early_thr,
  output logic              early_exit,
`endif
  output logic              busy,
  output logic              done,
  output logic              fit_req,
  input  logic              fit_ack,
  output logic [IDX_W-1:0]  fit_idx_a,
  output logic [IDX_W-1:0]  fit_idx_b,
  input  logic              fit_done,
  input  logic              fit_ok,
  output logic              pt_valid,
  output logic [IDX_W-1:0]  pt_idx,
  input  logic              inl_valid,
  input  logic              inl_hit,
  output logic              best_valid,
  output logic [CNT_W-1:0]  best_cnt,
  output logic [ITER_W-1:0] best_iter,
  output logic [IDX_W-1:0]  best_a,
  output logic [IDX_W-1:0]  best_b
);

  ransac_state_e state_q, state_d;

  logic [CNT_W-1:0]  np_q, np_d;
  logic [ITER_W-1:0] ni_q, ni_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [IDX_W-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0]  cur_q, cur_d, resp_q, resp_d;
  logic              best_valid_q, best_valid_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic [ITER_W-1:0] best_iter_q, best_iter_d;
  logic [IDX_W-1:0]  best_a_q, best_a_d, best_b_q, best_b_d;

  logic [IDX_W-1:0]  cand;
  logic [CNT_W-1:0]  np_clamped;
  logic [ITER_W-1:0] iter_inc;
  logic start_run, run_trivial, lfsr_en;
  logic cand_a_ok, cand_b_ok, scan_last, drained, take_best, last_iter, early_hit;

  // ---------------------------------------------------------------- helpers
  assign start_run   = (state_q == IDLE) && start;
  // Indices beyond the point buffer can never be scored.
  assign np_clamped  = (num_points > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : num_points;
  assign run_trivial = (num_points < CNT_W'(2)) || (num_iters == '0);
  assign lfsr_en     = (state_q == PICK_A) || (state_q == PICK_B);

  // Rejection sampling: candidates outside the buffer (or equal to the first
  // pick) are discarded and the LFSR simply moves on next cycle.
  assign cand_a_ok = CNT_W'(cand) < np_q;
  assign cand_b_ok = cand_a_ok && (cand != idx_a_q);
  assign scan_last = CNT_W'(scan_q) == (np_q - CNT_W'(1));
  assign drained   = resp_q == np_q;
  // Strict comparison: on a tie the earlier model is kept.
  assign take_best = !best_valid_q || (cur_q > best_cnt_q);
  assign iter_inc  = iter_q + ITER_W'(1);
  assign last_iter = iter_inc == ni_q;

  ransac_lfsr16 #(.OUT_W(IDX_W)) u_lfsr (
    .clk_i  (CLOCK_50),
    .rst_ni (KEY),
    .en_i   (lfsr_en),
    .load_i (start_run),
    .seed_i (seed),
    .state_o(cand)
  );

`ifdef RANSAC_EARLY_EXIT_EN
  logic [CNT_W-1:0] thr_q, thr_d, new_best;
  logic             early_q, early_d;

  // Compare against the best count as it will be after this UPDATE.
  assign new_best  = take_best ? cur_q : best_cnt_q;
  assign early_hit = (thr_q != '0) && (new_best >= thr_q);

  always_comb begin
    thr_d   = thr_q;
    early_d = early_q;
    if (start_run) begin
      thr_d   = early_thr;
      early_d = 1'b0;
    end else if (state_q == UPDATE && early_hit) begin
      early_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      thr_q   <= '0;
      early_q <= 1'b0;
    end else begin
      thr_q   <= thr_d;
      early_q <= early_d;
    end
  end

  assign early_exit = early_q;
`else
  assign early_hit = 1'b0;
`endif

  // ---------------------------------------------------------- state register
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = run_trivial ? FINISH : PICK_A;
      PICK_A:   if (cand_a_ok) state_d = PICK_B;
      PICK_B:   if (cand_b_ok) state_d = REQ;
      REQ:      if (fit_ack) state_d = WAIT_FIT;
      WAIT_FIT: if (fit_done) state_d = fit_ok ? SCAN : NEXT;
      SCAN:     if (scan_last) state_d = DRAIN;
      DRAIN:    if (drained) state_d = UPDATE;
      UPDATE:   state_d = early_hit ? FINISH : NEXT;
      NEXT:     state_d = last_iter ? FINISH : PICK_A;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy      = (state_q != IDLE) && (state_q != FINISH);
    done      = 1'b0;
    fit_req   = 1'b0;
    fit_idx_a = '0;
    fit_idx_b = '0;
    pt_valid  = 1'b0;
    pt_idx    = '0;
    case (state_q)
      REQ: begin
        fit_req   = 1'b1;
        fit_idx_a = idx_a_q;
        fit_idx_b = idx_b_q;
      end
      SCAN: begin
        pt_valid = 1'b1;
        pt_idx   = scan_q;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign best_valid = best_valid_q;
  assign best_cnt   = best_cnt_q;
  assign best_iter  = best_iter_q;
  assign best_a     = best_a_q;
  assign best_b     = best_b_q;

  // --------------------------------------------------------------- datapath
  always_comb begin
    np_d         = np_q;
    ni_d         = ni_q;
    iter_d       = iter_q;
    idx_a_d      = idx_a_q;
    idx_b_d      = idx_b_q;
    scan_d       = scan_q;
    cur_d        = cur_q;
    resp_d       = resp_q;
    best_valid_d = best_valid_q;
    best_cnt_d   = best_cnt_q;
    best_iter_d  = best_iter_q;
    best_a_d     = best_a_q;
    best_b_d     = best_b_q;

    if (start_run) begin
      np_d         = np_clamped;
      ni_d         = num_iters;
      iter_d       = '0;
      scan_d       = '0;
      cur_d        = '0;
      resp_d       = '0;
      best_valid_d = 1'b0;
      best_cnt_d   = '0;
      best_iter_d  = '0;
      best_a_d     = '0;
      best_b_d     = '0;
    end

    if (state_q == PICK_A && cand_a_ok) idx_a_d = cand;
    if (state_q == PICK_B && cand_b_ok) idx_b_d = cand;
    if (state_q == SCAN)                scan_d  = scan_q + IDX_W'(1);

    // Scorer results only count while this iteration is being scored.
    if ((state_q == SCAN || state_q == DRAIN) && inl_valid) begin
      resp_d = resp_q + CNT_W'(1);
      if (inl_hit) cur_d = cur_q + CNT_W'(1);
    end

    if (state_q == UPDATE && take_best) begin
      best_valid_d = 1'b1;
      best_cnt_d   = cur_q;
      best_iter_d  = iter_q;
      best_a_d     = idx_a_q;
      best_b_d     = idx_b_q;
    end

    if (state_q == NEXT) begin
      iter_d = iter_inc;
      if (!last_iter) begin
        cur_d  = '0;
        resp_d = '0;
        scan_d = '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      np_q         <= '0;
      ni_q         <= '0;
      iter_q       <= '0;
      idx_a_q      <= '0;
      idx_b_q      <= '0;
      scan_q       <= '0;
      cur_q        <= '0;
      resp_q       <= '0;
      best_valid_q <= 1'b0;
      best_cnt_q   <= '0;
      best_iter_q  <= '0;
      best_a_q     <= '0;
      best_b_q     <= '0;
    end else begin
      np_q         <= np_d;
      ni_q         <= ni_d;
      iter_q       <= iter_d;
      idx_a_q      <= idx_a_d;
      idx_b_q      <= idx_b_d;
      scan_q       <= scan_d;
      cur_q        <= cur_d;
      resp_q       <= resp_d;
      best_valid_q <= best_valid_d;
      best_cnt_q   <= best_cnt_d;
      best_iter_q  <= best_iter_d;
      best_a_q     <= best_a_d;
      best_b_q     <= best_b_d;
    end
  end

endmodule

// File: tb/tb_ransac_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ransac_iter_ctrl
// Self-checking bench for ransac_iter_ctrl. Reactive fit-unit and scorer
// models answer the DUT; a run-level reference model predicts the drawn
// index pairs, the number of fits and scanned points, and the best model.
// Build with +define+RANSAC_EARLY_EXIT_EN to include the early-exit run.
// ---------------------------------------------------------------------------
module tb_ransac_iter_ctrl;

  localparam int IDX_W  = 6;
  localparam int ITER_W = 8;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              KEY = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_points = '0;
  logic [ITER_W-1:0] num_iters = '0;
  logic [15:0]       seed = '0;
`ifdef RANSAC_EARLY_EXIT_EN
  logic [CNT_W-1:0]  early_thr = '0;
  logic              early_exit;
`endif
  logic              busy, done, fit_req, pt_valid, best_valid;
  logic              fit_ack = 1'b0, fit_done = 1'b0, fit_ok = 1'b0;
  logic              inl_valid = 1'b0, inl_hit = 1'b0;
  logic [IDX_W-1:0]  fit_idx_a, fit_idx_b, pt_idx, best_a, best_b;
  logic [CNT_W-1:0]  best_cnt;
  logic [ITER_W-1:0] best_iter;

  always #5 clk = ~clk;

  ransac_iter_ctrl dut (
    .CLOCK_50  (clk),
    .KEY       (KEY),
    .start     (start),
    .num_points(num_points),
    .num_iters (num_iters),
    .seed      (seed),
`ifdef RANSAC_EARLY_EXIT_EN
    .early_thr (early_thr),
    .early_exit(early_exit),
`endif
    .busy      (busy),
    .done      (done),
    .fit_req   (fit_req),
    .fit_ack   (fit_ack),
    .fit_idx_a (fit_idx_a),
    .fit_idx_b (fit_idx_b),
    .fit_done  (fit_done),
    .fit_ok    (fit_ok),
    .pt_valid  (pt_valid),
    .pt_idx    (pt_idx),
    .inl_valid (inl_valid),
    .inl_hit   (inl_hit),
    .best_valid(best_valid),
    .best_cnt  (best_cnt),
    .best_iter (best_iter),
    .best_a    (best_a),
    .best_b    (best_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-iteration scorer verdicts and fit outcomes used by both the
  // responders and the reference model.
  logic [63:0] hit_tbl [0:255];
  bit          ok_tbl  [0:255];
  int fit_lat = 1, inl_lat = 1, ack_dly = 0;

  // Observations collected by the responder/monitor.
  int  hs_cnt = 0, pt_cnt = 0, pt_pos = 0, pt_err = 0, done_cnt = 0;
  bit  done_seen = 0;
  time done_t = 0;
  int  obs_a[$], obs_b[$];
  int  due_q[$], idx_q[$];
  int  cyc = 0, fit_cd = 0, req_age = 0;

  // Fit unit and scorer models; react on the falling edge so inputs are
  // settled well before the DUT samples them.
  always @(negedge clk) begin
    cyc++;
    if (!KEY) begin
      due_q.delete();
      idx_q.delete();
      fit_cd = 0; req_age = 0;
      fit_ack = 0; fit_done = 0; fit_ok = 0; inl_valid = 0; inl_hit = 0;
    end else begin
      inl_valid = 0; inl_hit = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        inl_valid = 1;
        inl_hit   = hit_tbl[hs_cnt-1][idx_q[0]];
        void'(due_q.pop_front());
        void'(idx_q.pop_front());
      end
      if (pt_valid) begin
        pt_cnt++;
        if (int'(pt_idx) != pt_pos) pt_err++;
        pt_pos++;
        due_q.push_back(cyc + inl_lat);
        idx_q.push_back(int'(pt_idx));
      end
      fit_done = 0; fit_ok = 0;
      if (fit_cd > 0) begin
        fit_cd--;
        if (fit_cd == 0) begin
          fit_done = 1;
          fit_ok   = ok_tbl[hs_cnt-1];
        end
      end
      fit_ack = 0;
      if (fit_req) begin
        if (req_age >= ack_dly) begin
          fit_ack = 1;
          obs_a.push_back(int'(fit_idx_a));
          obs_b.push_back(int'(fit_idx_b));
          hs_cnt++;
          pt_pos  = 0;
          fit_cd  = fit_lat;
          req_age = 0;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1;
        done_t    = $time;
      end
    end
  end

  function automatic int lfsr_adv(input int l);
    int fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return ((l >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction

  // mode 0: even indices hit; 1: iteration 2 scores 8, others <= 6;
  // 2: random; 3: iteration 0 scores 3, iteration 1 scores 7, rest all.
  task automatic fill_hits(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: hit_tbl[i] = 64'h5555_5555_5555_5555;
        1: hit_tbl[i] = (i == 2) ? 64'hFF : ((64'd1 << ((i * 5 + 1) % 7)) - 64'd1);
        2: hit_tbl[i] = {$urandom, $urandom};
        default: hit_tbl[i] = (i == 0) ? 64'h7 : ((i == 1) ? 64'h7F : '1);
      endcase
    end
  endtask

  // mode 0: all degenerate; 1: all good; 2: mostly good
  task automatic fill_ok(input int mode);
    for (int i = 0; i < 256; i++)
      ok_tbl[i] = (mode == 1) ? 1'b1 : ((mode == 0) ? 1'b0 : ($urandom_range(0, 4) != 0));
  endtask

  task automatic rand_timing();
    fit_lat = $urandom_range(1, 3);
    inl_lat = $urandom_range(1, 4);
    ack_dly = $urandom_range(0, 2);
  endtask

  task automatic run(input int n, input int iters, input int sd, input bit spur, input int thr);
    int ea[$], eb[$];
    int l, a, b, sc, exp_hs, exp_pts, bc, bi, ba, bb, pair_err;
    bit bv, ee, trivial;
    logic [63:0] m;
    time t0;

    // Reference model: walk the LFSR sequence with rejection sampling.
    exp_hs = 0; exp_pts = 0; bv = 0; bc = 0; bi = 0; ba = 0; bb = 0; ee = 0;
    trivial = (n < 2) || (iters == 0);
    l = (sd == 0) ? 16'hACE1 : sd;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (!trivial) begin
      for (int i = 0; i < iters; i++) begin
        while ((l & 63) >= n) l = lfsr_adv(l);
        a = l & 63;
        l = lfsr_adv(l);
        while ((l & 63) >= n || (l & 63) == a) l = lfsr_adv(l);
        b = l & 63;
        l = lfsr_adv(l);
        ea.push_back(a);
        eb.push_back(b);
        exp_hs++;
        if (ok_tbl[i]) begin
          exp_pts += n;
          sc = $countones(hit_tbl[i] & m);
          if (!bv || sc > bc) begin
            bv = 1; bc = sc; bi = i; ba = a; bb = b;
          end
          if (thr != 0 && bc >= thr) begin
            ee = 1;
            break;
          end
        end
      end
    end

    hs_cnt = 0; pt_cnt = 0; pt_err = 0; done_cnt = 0; done_seen = 0;
    obs_a.delete();
    obs_b.delete();

    @(negedge clk);
    num_points = CNT_W'(n);
    num_iters  = ITER_W'(iters);
    seed       = 16'(sd);
`ifdef RANSAC_EARLY_EXIT_EN
    early_thr  = CNT_W'(thr);
`endif
    start = 1;
    t0 = $time;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, !trivial);

    for (int k = 0; k < 30000 && !done_seen; k++) begin
      @(negedge clk);
      if (spur && k == 4) begin
        start = 1; num_points = 7'd3; num_iters = 8'd1;
      end else if (spur && k == 5) begin
        start = 0; num_points = CNT_W'(n); num_iters = ITER_W'(iters);
      end
    end
    start = 0;
    chk("done_seen", done_seen, 1);
    if (trivial) chk("trivial_done_latency", (done_t - t0) <= 20, 1);
    repeat (3) @(negedge clk);

    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("fit_count", hs_cnt, exp_hs);
    chk("pt_count", pt_cnt, exp_pts);
    chk("pt_sequence_errs", pt_err, 0);
    pair_err = 0;
    for (int i = 0; i < exp_hs && i < obs_a.size(); i++)
      if (obs_a[i] != ea[i] || obs_b[i] != eb[i]) pair_err++;
    chk("pair_errs", pair_err, 0);
    chk("best_valid", best_valid, bv);
    chk("best_cnt", best_cnt, bc);
    chk("best_iter", best_iter, bi);
    chk("best_a", best_a, ba);
    chk("best_b", best_b, bb);
`ifdef RANSAC_EARLY_EXIT_EN
    chk("early_exit", early_exit, ee);
`endif
    $display("run n=%0d iters=%0d seed=%04h fits=%0d pts=%0d best_valid=%0d best=%0d@%0d pair=(%0d,%0d)",
             n, iters, sd, hs_cnt, pt_cnt, best_valid, best_cnt, best_iter, best_a, best_b);
  endtask

  task automatic reset_mid_scan();
    fill_hits(2);
    fill_ok(1);
    rand_timing();
    @(negedge clk);
    num_points = 7'd64; num_iters = 8'd3; seed = 16'($urandom); start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 500 && !pt_valid; k++) @(negedge clk);
    chk("scan_reached", pt_valid, 1);
    repeat (10) @(negedge clk);
    KEY = 0;
    #1;
    chk("abort_ctrl", {busy, done, fit_req, pt_valid, pt_idx, fit_idx_a, fit_idx_b}, 0);
    chk("abort_best", {best_valid, best_cnt, best_iter, best_a, best_b}, 0);
    repeat (2) @(negedge clk);
    KEY = 1;
    @(negedge clk);
    $display("reset asserted mid-scan, outputs busy=%0d pt_valid=%0d", busy, pt_valid);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    KEY = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, fit_req, pt_valid, pt_idx, best_valid, best_cnt, best_iter}, 0);
    KEY = 1;
    @(negedge clk);
    chk("idle_outputs", {busy, done, fit_req, pt_valid, best_valid, best_a, best_b}, 0);

    // Even indices are inliers: every iteration ties at 5, first one kept.
    fill_hits(0); fill_ok(1);
    fit_lat = 1; inl_lat = 3; ack_dly = 0;
    run(10, 4, 1, 0, 0);

    // Iteration 2 is the clear winner.
    fill_hits(1); fill_ok(1); rand_timing();
    run(10, 5, int'($urandom_range(1, 65535)), 0, 0);

    // Every fit degenerate: no scanning, no best model.
    fill_hits(2); fill_ok(0); rand_timing();
    run(12, 3, int'($urandom_range(0, 65535)), 0, 0);

    // Trivial runs finish without fitting.
    fill_ok(1);
    run(1, 3, 5, 0, 0);
    run(10, 0, 5, 0, 0);

    reset_mid_scan();
    fill_hits(2); fill_ok(1); rand_timing();
    run(64, 2, int'($urandom_range(0, 65535)), 0, 0);

    // start pulsed mid-run must be ignored.
    fill_hits(2); fill_ok(2); rand_timing();
    run(20, 4, int'($urandom_range(1, 65535)), 1, 0);

    // Zero seed falls back to the default LFSR state.
    run(16, 2, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_hits(2); fill_ok(2); rand_timing();
      run(int'($urandom_range(2, 64)), int'($urandom_range(1, 6)),
          int'($urandom_range(0, 65535)), 0, 0);
    end

`ifdef RANSAC_EARLY_EXIT_EN
    fill_hits(3); fill_ok(1); rand_timing();
    run(10, 20, int'($urandom_range(1, 65535)), 0, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
